// File: rtl/spadm_pkg.sv
// Shared types for the M scratchpad write-posting buffer: widths, posted-entry layout,
// array-port cycle class and the byte-lane merge used by forwarding and coalescing.
package spadm_pkg;

  localparam int SPADM_AW = 4;
  localparam int SPADM_DW = 32;
  localparam int SPADM_NB = SPADM_DW / 8;

  typedef struct packed {
    logic [SPADM_AW-1:0] addr;
    logic [SPADM_DW-1:0] data;
    logic [SPADM_NB-1:0] bmask;
  } spadm_entry_t;

  typedef enum logic [1:0] {
    CYC_IDLE,
    CYC_READ,
    CYC_DRAIN,
    CYC_FULL
  } spadm_cyc_e;

  function automatic logic [SPADM_DW-1:0] spadm_byte_merge(
    input logic [SPADM_DW-1:0] old_dat,
    input logic [SPADM_DW-1:0] new_dat,
    input logic [SPADM_NB-1:0] bmask
  );
    logic [SPADM_DW-1:0] r;
    r = old_dat;
    for (int b = 0; b < SPADM_NB; b++) begin
      if (bmask[b]) r[8*b +: 8] = new_dat[8*b +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/spadm_fwd_merge.sv
// Per-byte newest-match selector: pending entries override the inverted array data.
// Purely combinational; entry index DEPTH-1 is the newest, so later indices win.
module spadm_fwd_merge
  import spadm_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int AW    = SPADM_AW
) (
  input  logic [DEPTH-1:0]          ent_vld_i,
  input  logic [DEPTH*AW-1:0]       ent_addr_i,
  input  logic [DEPTH*SPADM_DW-1:0] ent_data_i,
  input  logic [DEPTH*SPADM_NB-1:0] ent_bmask_i,
  input  logic [AW-1:0]             rd_addr_i,
  input  logic [SPADM_DW-1:0]       mbus_l_i,
  output logic [SPADM_DW-1:0]       rd_data_o
);

  always_comb begin
    rd_data_o = ~mbus_l_i;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_vld_i[i] && (ent_addr_i[i*AW +: AW] == rd_addr_i)) begin
        rd_data_o = spadm_byte_merge(rd_data_o, ent_data_i[i*SPADM_DW +: SPADM_DW],
                                     ent_bmask_i[i*SPADM_NB +: SPADM_NB]);
      end
    end
  end

endmodule

// File: rtl/spadm_wrbuf.sv
// Write-posting buffer for the MTMP scratchpad: reads win the shared array port (data 1 cycle later),
// posted writes drain when idle; when full the head drains and stall_h holds requests. SPADM_COALESCE_EN merges same-address writes into the tail.
module spadm_wrbuf
  import spadm_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int AW    = SPADM_AW
) (
  input  logic                clk_h,
  input  logic                reset_h,
  input  logic                wr_req_h,
  input  logic [AW-1:0]       wr_addr_h,
  input  logic [SPADM_NB-1:0] wr_bmask_h,
  input  logic [SPADM_DW-1:0] wbus_h,
  input  logic                rd_req_h,
  input  logic [AW-1:0]       rd_addr_h,
  input  logic [SPADM_DW-1:0] mbus_l,
  output logic [AW-1:0]       mspa_h,
  output logic [SPADM_NB-1:0] spw_l,
  output logic                mcs_tmp_l,
  output logic [SPADM_DW-1:0] wdata_h,
  output logic [SPADM_DW-1:0] mdata_h,
  output logic                rd_vld_h,
  output logic                stall_h
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
`ifdef SPADM_COALESCE_EN
  localparam bit COALESCE = 1'b1;
`else
  localparam bit COALESCE = 1'b0;
`endif

  spadm_entry_t        ent_q [DEPTH];
  spadm_entry_t        ent_d [DEPTH];
  spadm_entry_t        ent_w [DEPTH];
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [AW-1:0]       addr_q;
  logic [SPADM_DW-1:0] mdata_q;
  logic                rd_vld_q;

  spadm_cyc_e          cyc;
  logic [AW-1:0]       tail_addr;
  logic                pop, wr_live, can_merge, do_merge, do_alloc, rd_acc;
  logic [SPADM_DW-1:0] fwd_data;

  logic [DEPTH-1:0]          fw_vld;
  logic [DEPTH*AW-1:0]       fw_addr;
  logic [DEPTH*SPADM_DW-1:0] fw_data;
  logic [DEPTH*SPADM_NB-1:0] fw_bmask;

  // Reset forces IDLE so the array sees no strobe while the FIFO is being cleared.
  always_comb begin
    if (reset_h)                cyc = CYC_IDLE;
    else if (cnt_q == FULL_CNT) cyc = CYC_FULL;
    else if (rd_req_h)          cyc = CYC_READ;
    else if (cnt_q != '0)       cyc = CYC_DRAIN;
    else                        cyc = CYC_IDLE;
  end

  always_comb begin
    tail_addr = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (cnt_q == CW'(i + 1)) tail_addr = ent_q[i].addr;
    end
  end

  assign pop       = (cyc == CYC_FULL) || (cyc == CYC_DRAIN);
  assign wr_live   = wr_req_h && (wr_bmask_h != '0);
  // A lone entry that is draining this cycle cannot absorb a merge.
  assign can_merge = COALESCE && wr_live && (cnt_q != '0) && (tail_addr == wr_addr_h)
                     && !(pop && (cnt_q == CW'(1)));
  assign stall_h   = (cyc == CYC_FULL) && (rd_req_h || (wr_req_h && !can_merge));
  assign do_merge  = can_merge && !stall_h;
  assign do_alloc  = wr_live && !do_merge && (cyc != CYC_FULL);
  assign rd_acc    = (cyc == CYC_READ);

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ent_w[i] = ent_q[i];
      if (do_merge && (cnt_q == CW'(i + 1))) begin
        ent_w[i].data  = spadm_byte_merge(ent_q[i].data, wbus_h, wr_bmask_h);
        ent_w[i].bmask = ent_q[i].bmask | wr_bmask_h;
      end
      if (do_alloc && (cnt_q == CW'(i))) begin
        ent_w[i].addr  = wr_addr_h;
        ent_w[i].data  = wbus_h;
        ent_w[i].bmask = wr_bmask_h;
      end
    end
    for (int i = 0; i < DEPTH; i++) begin
      ent_d[i] = ent_w[i];
      if (pop) ent_d[i] = (i < DEPTH - 1) ? ent_w[(i + 1) % DEPTH] : '0;
    end
    cnt_d = cnt_q;
    if (do_alloc && !pop)      cnt_d = cnt_q + CW'(1);
    else if (!do_alloc && pop) cnt_d = cnt_q - CW'(1);
  end

  always_comb begin
    mspa_h    = addr_q;
    spw_l     = '1;
    mcs_tmp_l = 1'b1;
    unique case (cyc)
      CYC_READ: begin
        mspa_h    = rd_addr_h;
        mcs_tmp_l = 1'b0;
      end
      CYC_DRAIN, CYC_FULL: begin
        mspa_h = ent_q[0].addr;
        spw_l  = ~ent_q[0].bmask;
      end
      default: ;
    endcase
  end

  assign wdata_h = ent_q[0].data;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      fw_vld[i]                        = (cnt_q > CW'(i));
      fw_addr[i*AW +: AW]              = ent_q[i].addr;
      fw_data[i*SPADM_DW +: SPADM_DW]  = ent_q[i].data;
      fw_bmask[i*SPADM_NB +: SPADM_NB] = ent_q[i].bmask;
    end
  end

  spadm_fwd_merge #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fwd (
    .ent_vld_i   (fw_vld),
    .ent_addr_i  (fw_addr),
    .ent_data_i  (fw_data),
    .ent_bmask_i (fw_bmask),
    .rd_addr_i   (rd_addr_h),
    .mbus_l_i    (mbus_l),
    .rd_data_o   (fwd_data)
  );

  always_ff @(posedge clk_h or posedge reset_h) begin
    if (reset_h) begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
      cnt_q    <= '0;
      addr_q   <= '0;
      mdata_q  <= '0;
      rd_vld_q <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= ent_d[i];
      cnt_q    <= cnt_d;
      addr_q   <= mspa_h;
      rd_vld_q <= rd_acc;
      if (rd_acc) mdata_q <= fwd_data;
    end
  end

  assign mdata_h  = mdata_q;
  assign rd_vld_h = rd_vld_q;

endmodule

// File: tb/tb_spadm_wrbuf.sv
// Directed bench for spadm_wrbuf with a behavioural model of the active-low MTMP array.
module tb_spadm_wrbuf;

  logic        clk = 1'b0;
  logic        reset_h;
  logic        wr_req_h;
  logic [3:0]  wr_addr_h;
  logic [3:0]  wr_bmask_h;
  logic [31:0] wbus_h;
  logic        rd_req_h;
  logic [3:0]  rd_addr_h;
  logic [31:0] mbus_l;
  logic [3:0]  mspa_h;
  logic [3:0]  spw_l;
  logic        mcs_tmp_l;
  logic [31:0] wdata_h;
  logic [31:0] mdata_h;
  logic        rd_vld_h;
  logic        stall_h;

  int nvec = 0;
  int nerr = 0;

  logic [31:0] mem [16];

  always #5 clk = ~clk;

  spadm_wrbuf #(.DEPTH(2), .AW(4)) dut (
    .clk_h      (clk),
    .reset_h    (reset_h),
    .wr_req_h   (wr_req_h),
    .wr_addr_h  (wr_addr_h),
    .wr_bmask_h (wr_bmask_h),
    .wbus_h     (wbus_h),
    .rd_req_h   (rd_req_h),
    .rd_addr_h  (rd_addr_h),
    .mbus_l     (mbus_l),
    .mspa_h     (mspa_h),
    .spw_l      (spw_l),
    .mcs_tmp_l  (mcs_tmp_l),
    .wdata_h    (wdata_h),
    .mdata_h    (mdata_h),
    .rd_vld_h   (rd_vld_h),
    .stall_h    (stall_h)
  );

  // Array model: combinational active-low read, byte-strobed write on the rising edge.
  assign mbus_l = ~mem[mspa_h];

  always @(posedge clk or posedge reset_h) begin
    if (reset_h) begin
      for (int i = 0; i < 16; i++) mem[i] <= 32'h0;
      mem[5] <= 32'h11223344;
    end else begin
      for (int b = 0; b < 4; b++) begin
        if (!spw_l[b]) mem[mspa_h][8*b +: 8] <= wdata_h[8*b +: 8];
      end
    end
  end

  task automatic drive(input logic rd, input logic [3:0] ra, input logic wr,
                       input logic [3:0] wa, input logic [3:0] wm, input logic [31:0] wd);
    @(negedge clk);
    rd_req_h   = rd;
    rd_addr_h  = ra;
    wr_req_h   = wr;
    wr_addr_h  = wa;
    wr_bmask_h = wm;
    wbus_h     = wd;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 4'h0, 1'b0, 4'h0, 4'h0, 32'h0);
  endtask

  task automatic test_reset();
    #2;
    nvec++; if (spw_l !== 4'hF)      begin nerr++; $display("FAIL rst_spw got=%h exp=F", spw_l); end
    nvec++; if (mcs_tmp_l !== 1'b1)  begin nerr++; $display("FAIL rst_mcs got=%b exp=1", mcs_tmp_l); end
    nvec++; if (mspa_h !== 4'h0)     begin nerr++; $display("FAIL rst_mspa got=%h exp=0", mspa_h); end
    nvec++; if (stall_h !== 1'b0)    begin nerr++; $display("FAIL rst_stall got=%b exp=0", stall_h); end
    nvec++; if (rd_vld_h !== 1'b0)   begin nerr++; $display("FAIL rst_vld got=%b exp=0", rd_vld_h); end
    nvec++; if (mdata_h !== 32'h0)   begin nerr++; $display("FAIL rst_mdata got=%h exp=0", mdata_h); end
    @(negedge clk);
    reset_h = 1'b0;
    idle();
    idle();
    nvec++; if (spw_l !== 4'hF)      begin nerr++; $display("FAIL idle_spw got=%h exp=F", spw_l); end
    nvec++; if (mcs_tmp_l !== 1'b1)  begin nerr++; $display("FAIL idle_mcs got=%b exp=1", mcs_tmp_l); end
    nvec++; if (stall_h !== 1'b0)    begin nerr++; $display("FAIL idle_stall got=%b exp=0", stall_h); end
    nvec++; if (rd_vld_h !== 1'b0)   begin nerr++; $display("FAIL idle_vld got=%b exp=0", rd_vld_h); end
  endtask

  task automatic test_write_drain();
    drive(1'b0, 4'h0, 1'b1, 4'h3, 4'hF, 32'hDEADBEEF);
    nvec++; if (stall_h !== 1'b0)    begin nerr++; $display("FAIL wd_stall got=%b exp=0", stall_h); end
    nvec++; if (spw_l !== 4'hF)      begin nerr++; $display("FAIL wd_post_spw got=%h exp=F", spw_l); end
    idle();
    nvec++; if (spw_l !== 4'h0)      begin nerr++; $display("FAIL wd_drain_spw got=%h exp=0", spw_l); end
    nvec++; if (mspa_h !== 4'h3)     begin nerr++; $display("FAIL wd_drain_mspa got=%h exp=3", mspa_h); end
    nvec++; if (wdata_h !== 32'hDEADBEEF) begin nerr++; $display("FAIL wd_drain_wdata got=%h exp=deadbeef", wdata_h); end
    idle();
    nvec++; if (spw_l !== 4'hF)      begin nerr++; $display("FAIL wd_once_spw got=%h exp=F", spw_l); end
    nvec++; if (mspa_h !== 4'h3)     begin nerr++; $display("FAIL wd_hold_mspa got=%h exp=3", mspa_h); end
    drive(1'b1, 4'h3, 1'b0, 4'h0, 4'h0, 32'h0);
    nvec++; if (mcs_tmp_l !== 1'b0)  begin nerr++; $display("FAIL wd_rd_mcs got=%b exp=0", mcs_tmp_l); end
    idle();
    nvec++; if (rd_vld_h !== 1'b1)   begin nerr++; $display("FAIL wd_rd_vld got=%b exp=1", rd_vld_h); end
    nvec++; if (mdata_h !== 32'hDEADBEEF) begin nerr++; $display("FAIL wd_rd_data got=%h exp=deadbeef", mdata_h); end
    idle();
    nvec++; if (rd_vld_h !== 1'b0)   begin nerr++; $display("FAIL wd_vld_pulse got=%b exp=0", rd_vld_h); end
    nvec++; if (mdata_h !== 32'hDEADBEEF) begin nerr++; $display("FAIL wd_data_hold got=%h exp=deadbeef", mdata_h); end
  endtask

  task automatic test_fwd_merge();
    drive(1'b0, 4'h0, 1'b1, 4'h5, 4'b0101, 32'hAABBCCDD);
    drive(1'b1, 4'h5, 1'b0, 4'h0, 4'h0, 32'h0);
    nvec++; if (spw_l !== 4'hF)      begin nerr++; $display("FAIL fm_rd_spw got=%h exp=F", spw_l); end
    drive(1'b1, 4'h5, 1'b0, 4'h0, 4'h0, 32'h0);
    nvec++; if (rd_vld_h !== 1'b1)   begin nerr++; $display("FAIL fm_vld got=%b exp=1", rd_vld_h); end
    nvec++; if (mdata_h !== 32'h11BB33DD) begin nerr++; $display("FAIL fm_data got=%h exp=11bb33dd", mdata_h); end
    idle();
    nvec++; if (mdata_h !== 32'h11BB33DD) begin nerr++; $display("FAIL fm_data2 got=%h exp=11bb33dd", mdata_h); end
    nvec++; if (spw_l !== 4'b1010)   begin nerr++; $display("FAIL fm_drain_spw got=%h exp=a", spw_l); end
    nvec++; if (mspa_h !== 4'h5)     begin nerr++; $display("FAIL fm_drain_mspa got=%h exp=5", mspa_h); end
    drive(1'b1, 4'h5, 1'b0, 4'h0, 4'h0, 32'h0);
    idle();
    nvec++; if (mdata_h !== 32'h11BB33DD) begin nerr++; $display("FAIL fm_array got=%h exp=11bb33dd", mdata_h); end
  endtask

  task automatic test_full_stall();
    drive(1'b1, 4'h0, 1'b1, 4'h8, 4'hF, 32'h08080808);
    nvec++; if (stall_h !== 1'b0)    begin nerr++; $display("FAIL fs_c1_stall got=%b exp=0", stall_h); end
    drive(1'b1, 4'h0, 1'b1, 4'h9, 4'hF, 32'h09090909);
    nvec++; if (stall_h !== 1'b0)    begin nerr++; $display("FAIL fs_c2_stall got=%b exp=0", stall_h); end
    drive(1'b1, 4'h0, 1'b1, 4'hA, 4'hF, 32'h0A0A0A0A);
    nvec++; if (stall_h !== 1'b1)    begin nerr++; $display("FAIL fs_full_stall got=%b exp=1", stall_h); end
    nvec++; if (spw_l !== 4'h0)      begin nerr++; $display("FAIL fs_full_spw got=%h exp=0", spw_l); end
    nvec++; if (mspa_h !== 4'h8)     begin nerr++; $display("FAIL fs_full_mspa got=%h exp=8", mspa_h); end
    nvec++; if (wdata_h !== 32'h08080808) begin nerr++; $display("FAIL fs_full_wdata got=%h exp=08080808", wdata_h); end
    nvec++; if (mcs_tmp_l !== 1'b1)  begin nerr++; $display("FAIL fs_full_mcs got=%b exp=1", mcs_tmp_l); end
    drive(1'b1, 4'h0, 1'b1, 4'hA, 4'hF, 32'h0A0A0A0A);
    nvec++; if (stall_h !== 1'b0)    begin nerr++; $display("FAIL fs_acc_stall got=%b exp=0", stall_h); end
    nvec++; if (mcs_tmp_l !== 1'b0)  begin nerr++; $display("FAIL fs_acc_mcs got=%b exp=0", mcs_tmp_l); end
    nvec++; if (rd_vld_h !== 1'b0)   begin nerr++; $display("FAIL fs_stalled_vld got=%b exp=0", rd_vld_h); end
    idle();
    nvec++; if (rd_vld_h !== 1'b1)   begin nerr++; $display("FAIL fs_acc_vld got=%b exp=1", rd_vld_h); end
    nvec++; if (mspa_h !== 4'h9)     begin nerr++; $display("FAIL fs_d9_mspa got=%h exp=9", mspa_h); end
    nvec++; if (spw_l !== 4'h0)      begin nerr++; $display("FAIL fs_d9_spw got=%h exp=0", spw_l); end
    idle();
    nvec++; if (mspa_h !== 4'hA)     begin nerr++; $display("FAIL fs_da_mspa got=%h exp=a", mspa_h); end
    nvec++; if (wdata_h !== 32'h0A0A0A0A) begin nerr++; $display("FAIL fs_da_wdata got=%h exp=0a0a0a0a", wdata_h); end
    idle();
    nvec++; if (spw_l !== 4'hF)      begin nerr++; $display("FAIL fs_empty_spw got=%h exp=F", spw_l); end
  endtask

  task automatic test_same_cycle();
    drive(1'b1, 4'h7, 1'b1, 4'h7, 4'hF, 32'h1);
    drive(1'b1, 4'h7, 1'b0, 4'h0, 4'h0, 32'h0);
    nvec++; if (mdata_h !== 32'h0)   begin nerr++; $display("FAIL sc_pre got=%h exp=0", mdata_h); end
    idle();
    nvec++; if (mdata_h !== 32'h1)   begin nerr++; $display("FAIL sc_post got=%h exp=1", mdata_h); end
    nvec++; if (spw_l !== 4'h0)      begin nerr++; $display("FAIL sc_drain_spw got=%h exp=0", spw_l); end
    idle();
  endtask

  task automatic test_zero_mask();
    drive(1'b0, 4'h0, 1'b1, 4'h4, 4'h0, 32'hFFFFFFFF);
    nvec++; if (stall_h !== 1'b0)    begin nerr++; $display("FAIL zm_stall got=%b exp=0", stall_h); end
    idle();
    nvec++; if (spw_l !== 4'hF)      begin nerr++; $display("FAIL zm_spw got=%h exp=F", spw_l); end
    drive(1'b1, 4'h4, 1'b0, 4'h0, 4'h0, 32'h0);
    idle();
    nvec++; if (mdata_h !== 32'h0)   begin nerr++; $display("FAIL zm_data got=%h exp=0", mdata_h); end
  endtask

  task automatic test_coalesce();
    drive(1'b1, 4'h0, 1'b1, 4'h2, 4'b0001, 32'h000000AA);
    drive(1'b1, 4'h0, 1'b1, 4'h2, 4'b0010, 32'h0000BB00);
    nvec++; if (stall_h !== 1'b0)    begin nerr++; $display("FAIL co_stall got=%b exp=0", stall_h); end
    idle();
    nvec++; if (mspa_h !== 4'h2)     begin nerr++; $display("FAIL co_mspa got=%h exp=2", mspa_h); end
`ifdef SPADM_COALESCE_EN
    nvec++; if (spw_l !== 4'b1100)   begin nerr++; $display("FAIL co_spw got=%h exp=c", spw_l); end
    nvec++; if (wdata_h[15:0] !== 16'hBBAA) begin nerr++; $display("FAIL co_wdata got=%h exp=bbaa", wdata_h[15:0]); end
    idle();
    nvec++; if (spw_l !== 4'hF)      begin nerr++; $display("FAIL co_once got=%h exp=F", spw_l); end
`else
    nvec++; if (spw_l !== 4'b1110)   begin nerr++; $display("FAIL nc_spw0 got=%h exp=e", spw_l); end
    nvec++; if (wdata_h[7:0] !== 8'hAA) begin nerr++; $display("FAIL nc_wdata0 got=%h exp=aa", wdata_h[7:0]); end
    idle();
    nvec++; if (spw_l !== 4'b1101)   begin nerr++; $display("FAIL nc_spw1 got=%h exp=d", spw_l); end
    nvec++; if (wdata_h[15:8] !== 8'hBB) begin nerr++; $display("FAIL nc_wdata1 got=%h exp=bb", wdata_h[15:8]); end
    idle();
    nvec++; if (spw_l !== 4'hF)      begin nerr++; $display("FAIL nc_once got=%h exp=F", spw_l); end
`endif
    drive(1'b1, 4'h2, 1'b0, 4'h0, 4'h0, 32'h0);
    idle();
    nvec++; if (mdata_h !== 32'h0000BBAA) begin nerr++; $display("FAIL co_array got=%h exp=0000bbaa", mdata_h); end
  endtask

  task automatic test_reset_mid_drain();
    drive(1'b0, 4'h0, 1'b1, 4'h6, 4'hF, 32'h12345678);
    idle();
    nvec++; if (spw_l !== 4'h0)      begin nerr++; $display("FAIL rm_drain_spw got=%h exp=0", spw_l); end
    reset_h = 1'b1;
    #1;
    nvec++; if (spw_l !== 4'hF)      begin nerr++; $display("FAIL rm_rst_spw got=%h exp=F", spw_l); end
    nvec++; if (mspa_h !== 4'h0)     begin nerr++; $display("FAIL rm_rst_mspa got=%h exp=0", mspa_h); end
    @(negedge clk);
    reset_h = 1'b0;
    idle();
    nvec++; if (spw_l !== 4'hF)      begin nerr++; $display("FAIL rm_discard_spw got=%h exp=F", spw_l); end
    nvec++; if (rd_vld_h !== 1'b0)   begin nerr++; $display("FAIL rm_vld got=%b exp=0", rd_vld_h); end
  endtask

  initial begin
    reset_h    = 1'b1;
    wr_req_h   = 1'b0;
    wr_addr_h  = 4'h0;
    wr_bmask_h = 4'h0;
    wbus_h     = 32'h0;
    rd_req_h   = 1'b0;
    rd_addr_h  = 4'h0;
    test_reset();
    test_write_drain();
    test_fwd_merge();
    test_full_stall();
    test_same_cycle();
    test_zero_mask();
    test_coalesce();
    test_reset_mid_drain();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
